// File: rtl/multi_timer_pkg.sv
// Shared constants for the multi-channel timer: register offsets, bit positions
// and the per-channel address stride.
package multi_timer_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned OFF_W     = 3;
  localparam int unsigned CH_STRIDE = 8;

  localparam logic [OFF_W-1:0] OFF_CTRL    = 3'd0;
  localparam logic [OFF_W-1:0] OFF_PERIOD  = 3'd1;
  localparam logic [OFF_W-1:0] OFF_COUNT   = 3'd2;
  localparam logic [OFF_W-1:0] OFF_STATUS  = 3'd3;
  localparam logic [OFF_W-1:0] OFF_COMPARE = 3'd4;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_CONT = 1;
  localparam int unsigned CTRL_IE   = 2;
  localparam int unsigned STATUS_TO = 0;

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: CTRL/PERIOD/COUNT/STATUS registers, down-counter, tick pulse.
// COMPARE register and PWM output exist only when MULTI_TIMER_PWM_EN is defined.
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [OFF_W-1:0]  addr_off,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data_c,
  output logic              tick,
  output logic              pwm,
  output logic              irq_c
);

  logic             en_q, en_d, cont_q, cont_d, ie_q, ie_d, to_q, to_d, tick_q, tick_d;
  logic [CNT_W-1:0] period_q, period_d, count_q, count_d;
  logic [DATA_W-1:0] compare_rd_c;
  logic             timeout_c;
  logic             unused_c;

  assign timeout_c = en_q && (count_q == '0);
  assign unused_c  = ^wr_data;

  // Ordering matters: hardware TO set overrides software clear, software EN overrides one-shot clear.
  always_comb begin
    en_d     = en_q;
    cont_d   = cont_q;
    ie_d     = ie_q;
    to_d     = to_q;
    period_d = period_q;
    count_d  = count_q;
    tick_d   = 1'b0;

    if (en_q && (count_q != '0)) count_d = count_q - CNT_W'(1);
    if (wr_en && (addr_off == OFF_STATUS) && wr_data[STATUS_TO]) to_d = 1'b0;

    if (timeout_c) begin
      to_d    = 1'b1;
      tick_d  = 1'b1;
      count_d = period_q;
      if (!cont_q) en_d = 1'b0;
    end

    if (wr_en) begin
      case (addr_off)
        OFF_CTRL: begin
          en_d   = wr_data[CTRL_EN];
          cont_d = wr_data[CTRL_CONT];
          ie_d   = wr_data[CTRL_IE];
          if (wr_data[CTRL_EN] && !en_q) count_d = period_q;
        end
        OFF_PERIOD: period_d = wr_data[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      ie_q     <= 1'b0;
      to_q     <= 1'b0;
      tick_q   <= 1'b0;
      period_q <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      cont_q   <= cont_d;
      ie_q     <= ie_d;
      to_q     <= to_d;
      tick_q   <= tick_d;
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0] compare_q, compare_d;
  logic             pwm_q, pwm_d;

  always_comb begin
    compare_d = compare_q;
    if (wr_en && (addr_off == OFF_COMPARE)) compare_d = wr_data[CNT_W-1:0];
    pwm_d = en_q && (count_q < compare_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      compare_q <= compare_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm          = pwm_q;
  assign compare_rd_c = DATA_W'(compare_q);
`else
  assign pwm          = 1'b0;
  assign compare_rd_c = '0;
`endif

  always_comb begin
    rd_data_c = '0;
    case (addr_off)
      OFF_CTRL: begin
        rd_data_c[CTRL_EN]   = en_q;
        rd_data_c[CTRL_CONT] = cont_q;
        rd_data_c[CTRL_IE]   = ie_q;
      end
      OFF_PERIOD:  rd_data_c = DATA_W'(period_q);
      OFF_COUNT:   rd_data_c = DATA_W'(count_q);
      OFF_STATUS:  rd_data_c[STATUS_TO] = to_q;
      OFF_COMPARE: rd_data_c = compare_rd_c;
      default: ;
    endcase
  end

  assign tick  = tick_q;
  assign irq_c = to_q & ie_q;

endmodule

// File: rtl/multi_timer.sv
// Avalon-MM multi-channel timer: address decode, registered read mux and irq OR
// over N_CH timer_channel instances. PWM support is enabled by MULTI_TIMER_PWM_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [$clog2(N_CH)+2:0]  avs_address,
  input  logic                     avs_write,
  input  logic                     avs_read,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq,
  output logic [N_CH-1:0]          tick_export,
  output logic [N_CH-1:0]          pwm_export
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [CH_W-1:0]   ch_sel_c;
  logic [OFF_W-1:0]  off_c;
  logic [DATA_W-1:0] ch_rd_c [N_CH];
  logic [N_CH-1:0]   ch_irq_c, ch_wr_c;
  logic [DATA_W-1:0] rd_mux_c, readdata_q, readdata_d;
  logic              irq_q, irq_d;

  assign ch_sel_c = CH_W'(avs_address >> OFF_W);
  assign off_c    = avs_address[OFF_W-1:0];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_wr_c[g] = avs_write && (ch_sel_c == CH_W'(g));

    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk_clk),
      .rst       (reset_reset),
      .wr_en     (ch_wr_c[g]),
      .addr_off  (off_c),
      .wr_data   (avs_writedata),
      .rd_data_c (ch_rd_c[g]),
      .tick      (tick_export[g]),
      .pwm       (pwm_export[g]),
      .irq_c     (ch_irq_c[g])
    );
  end

  // Channel indices beyond N_CH (non-power-of-two configs) read as zero.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_sel_c == CH_W'(i)) rd_mux_c = ch_rd_c[i];
    end
    readdata_d = avs_read ? rd_mux_c : readdata_q;
    irq_d      = |ch_irq_c;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avs_readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Self-checking bench for multi_timer: default 4x32 instance plus a 1x8 instance.
module tb_multi_timer;
  import multi_timer_pkg::*;

`ifdef MULTI_TIMER_PWM_EN
  localparam bit PWM_BUILD = 1'b1;
`else
  localparam bit PWM_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  avs_address;
  logic        avs_write, avs_read;
  logic [31:0] avs_writedata, avs_readdata;
  logic        irq;
  logic [3:0]  tick, pwm;

  logic [2:0]  s_address;
  logic        s_write, s_read;
  logic [31:0] s_writedata, s_readdata;
  logic        s_irq;
  logic [0:0]  s_tick, s_pwm;

  multi_timer #(.N_CH(4), .CNT_W(32)) u_dut (
    .clk_clk(clk), .reset_reset(rst), .avs_address(avs_address), .avs_write(avs_write),
    .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .irq(irq), .tick_export(tick), .pwm_export(pwm)
  );

  multi_timer #(.N_CH(1), .CNT_W(8)) u_small (
    .clk_clk(clk), .reset_reset(rst), .avs_address(s_address), .avs_write(s_write),
    .avs_read(s_read), .avs_writedata(s_writedata), .avs_readdata(s_readdata),
    .irq(s_irq), .tick_export(s_tick), .pwm_export(s_pwm)
  );

  int n_pass = 0;
  int n_total = 0;
  string       sb_name[$];
  logic [31:0] sb_exp[$];
  logic rd_seen = 1'b0, s_rd_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic sb_check(input logic [31:0] act);
    string       n;
    logic [31:0] e;
    if (sb_exp.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      n = sb_name.pop_front();
      e = sb_exp.pop_front();
      check(n, act, e);
    end
  endtask

  // Read data is due one cycle after the strobe; compare on the following falling edge.
  always @(posedge clk) begin
    rd_seen   <= avs_read;
    s_rd_seen <= s_read;
  end
  always @(negedge clk) begin
    if (rd_seen)   sb_check(avs_readdata);
    if (s_rd_seen) sb_check(s_readdata);
  end

  function automatic logic [4:0] ad(input int ch, input logic [2:0] off);
    return {2'(ch), off};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    avs_address = a; avs_read = 1'b1;
    sb_name.push_back(name); sb_exp.push_back(exp);
    @(negedge clk);
    avs_read = 1'b0;
  endtask

  task automatic swr(input logic [2:0] a, input logic [31:0] d);
    s_address = a; s_writedata = d; s_write = 1'b1;
    @(negedge clk);
    s_write = 1'b0;
  endtask

  task automatic srd(input logic [2:0] a, input logic [31:0] exp, input string name);
    s_address = a; s_read = 1'b1;
    sb_name.push_back(name); sb_exp.push_back(exp);
    @(negedge clk);
    s_read = 1'b0;
  endtask

  typedef struct {
    bit          is_wr;
    logic [4:0]  addr;
    logic [31:0] data;  // write data, or expected read data
  } vec_t;

  vec_t vecs [13];

  initial begin
    int cnt, first, first2, bad;

    vecs[0]  = '{1'b1, ad(3, OFF_PERIOD),  32'h0000_1234};
    vecs[1]  = '{1'b0, ad(3, OFF_PERIOD),  32'h0000_1234};
    vecs[2]  = '{1'b1, ad(3, OFF_COMPARE), 32'h0000_0010};
    vecs[3]  = '{1'b0, ad(3, OFF_COMPARE), PWM_BUILD ? 32'h10 : 32'h0};
    vecs[4]  = '{1'b1, ad(3, OFF_CTRL),    32'hFFFF_FFF6};
    vecs[5]  = '{1'b0, ad(3, OFF_CTRL),    32'h0000_0006};
    vecs[6]  = '{1'b1, ad(3, 3'd5),        32'hFFFF_FFFF};
    vecs[7]  = '{1'b0, ad(3, 3'd5),        32'h0};
    vecs[8]  = '{1'b0, ad(3, 3'd7),        32'h0};
    vecs[9]  = '{1'b0, ad(3, OFF_COUNT),   32'h0};
    vecs[10] = '{1'b1, ad(3, OFF_COUNT),   32'h0000_0055};
    vecs[11] = '{1'b0, ad(3, OFF_COUNT),   32'h0};
    vecs[12] = '{1'b0, ad(3, OFF_STATUS),  32'h0};

    rst = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    s_address = '0; s_write = 1'b0; s_read = 1'b0; s_writedata = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_readdata", avs_readdata, 32'h0);
    check("reset_outputs", {24'h0, pwm, tick}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_small", {29'h0, s_irq, s_tick, s_pwm}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rd(ad(0, OFF_CTRL), 32'h0, "reset_ctrl");
    rd(ad(0, OFF_COUNT), 32'h0, "reset_count");

    // Register map
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else rd(vecs[i].addr, vecs[i].data, $sformatf("tbl%0d", i));
    end

    // Continuous ch0, period 10
    wr(ad(0, OFF_PERIOD), 32'd9);
    wr(ad(0, OFF_CTRL), 32'h3);
    cnt = 0; first = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (tick[0]) begin cnt++; if (first < 0) first = k; end
    end
    check("cont_tick_count", 32'(cnt), 32'd3);
    check("cont_tick_first", 32'(first), 32'd10);
    for (int j = 0; j < 12; j++) rd(ad(0, OFF_COUNT), 32'(9 - (j % 10)), $sformatf("cont_count%0d", j));
    wr(ad(0, OFF_CTRL), 32'h0);

    // One-shot ch1 with interrupt
    wr(ad(1, OFF_PERIOD), 32'd4);
    wr(ad(1, OFF_CTRL), 32'h5);
    cnt = 0; first = -1; first2 = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tick[1]) begin cnt++; if (first < 0) first = k; end
      if (irq && first2 < 0) first2 = k;
    end
    check("oneshot_tick_count", 32'(cnt), 32'd1);
    check("oneshot_tick_first", 32'(first), 32'd5);
    check("oneshot_irq_first", 32'(first2), 32'd6);
    rd(ad(1, OFF_CTRL), 32'h4, "oneshot_ctrl");
    rd(ad(1, OFF_STATUS), 32'h1, "oneshot_status");
    wr(ad(1, OFF_STATUS), 32'h1);
    check("irq_clear_edge", {31'h0, irq}, 32'h1);
    @(negedge clk);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // ch2: TO clear coincident with hardware set
    wr(ad(2, OFF_PERIOD), 32'd4);
    wr(ad(2, OFF_CTRL), 32'h7);
    repeat (9) @(negedge clk);
    wr(ad(2, OFF_STATUS), 32'h1);
    check("coinc_tick", {31'h0, tick[2]}, 32'h1);
    check("coinc_irq", {31'h0, irq}, 32'h1);
    rd(ad(2, OFF_STATUS), 32'h1, "coinc_status");
    wr(ad(2, OFF_CTRL), 32'h4);

    // ch3: EN rewritten in the cycle a one-shot timeout clears it
    wr(ad(3, OFF_PERIOD), 32'd2);
    wr(ad(3, OFF_CTRL), 32'h1);
    repeat (2) @(negedge clk);
    wr(ad(3, OFF_CTRL), 32'h1);
    check("reen_tick", {31'h0, tick[3]}, 32'h1);
    rd(ad(3, OFF_COUNT), 32'd2, "reen_count");
    rd(ad(3, OFF_CTRL), 32'h1, "reen_ctrl");
    wr(ad(3, OFF_CTRL), 32'h0);

    // ch1: PERIOD=0 continuous ticks every cycle
    wr(ad(1, OFF_PERIOD), 32'd0);
    wr(ad(1, OFF_CTRL), 32'h3);
    cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tick[1]) cnt++;
    end
    check("period0_ticks", 32'(cnt), 32'd8);
    wr(ad(1, OFF_CTRL), 32'h0);

    // Reset mid-count on ch0 (COUNT=3)
    wr(ad(0, OFF_PERIOD), 32'd9);
    wr(ad(0, OFF_CTRL), 32'h3);
    rd(ad(0, OFF_PERIOD), 32'd9, "prereset_period");
    repeat (5) @(negedge clk);
    check("prereset_irq", {31'h0, irq}, 32'h1);
    rst = 1'b1;
    #1;
    check("midreset_readdata", avs_readdata, 32'h0);
    check("midreset_outputs", {23'h0, irq, pwm, tick}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rd(ad(0, OFF_COUNT), 32'h0, "postreset_count");
    rd(ad(0, OFF_CTRL), 32'h0, "postreset_ctrl");
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((|tick) || s_tick[0]) cnt++;
    end
    check("postreset_no_tick", 32'(cnt), 32'd0);

    // PWM on ch0: period 4, compare 1
    wr(ad(0, OFF_PERIOD), 32'd3);
    wr(ad(0, OFF_COMPARE), 32'd1);
    rd(ad(0, OFF_COMPARE), PWM_BUILD ? 32'd1 : 32'd0, "pwm_compare_rd");
    wr(ad(0, OFF_CTRL), 32'h3);
    cnt = 0; bad = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (pwm[0]) cnt++;
      if (pwm[0] !== (PWM_BUILD && (k % 4 == 0))) bad++;
    end
    check("pwm_high_count", 32'(cnt), PWM_BUILD ? 32'd4 : 32'd0);
    check("pwm_pattern_bad", 32'(bad), 32'd0);
    wr(ad(0, OFF_CTRL), 32'h0);

    // Narrow instance: truncated PERIOD, 256-cycle period
    swr(OFF_PERIOD, 32'h1FF);
    srd(OFF_PERIOD, 32'hFF, "small_period");
    swr(OFF_CTRL, 32'h3);
    cnt = 0; first = -1;
    for (int k = 1; k <= 520; k++) begin
      @(negedge clk);
      if (s_tick[0]) begin cnt++; if (first < 0) first = k; end
    end
    check("small_tick_count", 32'(cnt), 32'd2);
    check("small_tick_first", 32'(first), 32'd256);

    @(negedge clk);
    check("sb_drain", 32'(sb_exp.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent timer channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL have port clk_clk, input, 1, sole clock; all logic rising-edge.
REQ-004 SHALL have port reset_reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port avs_address, input, $clog2(N_CH)+3, word address: channel = address[MSB:3], register offset = address[2:0].
REQ-006 SHALL have ports avs_write and avs_read, input, 1 each, Avalon-MM strobes; no waitrequest.
REQ-007 SHALL have port avs_writedata, input, 32, write data.
REQ-008 SHALL have port avs_readdata, output, 32, registered read data.
REQ-009 SHALL have port irq, output, 1, level interrupt.
REQ-010 SHALL have port tick_export, output, N_CH, one-cycle timeout pulse per channel.
REQ-011 SHALL have port pwm_export, output, N_CH, per-channel PWM output.

Function
REQ-012 Per-channel register map SHALL be: 0 CTRL (bit0 EN, bit1 CONT, bit2 IE), 1 PERIOD, 2 COUNT (read-only), 3 STATUS (bit0 TO, write-1-to-clear), 4 COMPARE; other offsets read 0, writes ignored.
REQ-013 Writes SHALL take effect on the clock edge with avs_write high; unused upper bits of PERIOD/COUNT/COMPARE read 0.
REQ-014 avs_readdata SHALL be valid exactly one cycle after avs_read (fixed read latency 1) and hold until the next read.
REQ-015 A CTRL write changing EN 0->1 SHALL load COUNT with PERIOD on that edge.
REQ-016 While EN=1 and COUNT>0, COUNT SHALL decrement by 1 per cycle; while EN=0, COUNT SHALL hold.
REQ-017 When EN=1 and COUNT=0: TO SHALL set, tick_export[ch] SHALL pulse high one cycle, COUNT SHALL reload PERIOD; if CONT=0, EN SHALL clear on the same edge.
REQ-018 Timeout period SHALL be PERIOD+1 cycles; PERIOD=0 with CONT=1 SHALL tick every cycle.
REQ-019 PERIOD writes while running SHALL take effect only at the next reload or enable.
REQ-020 Hardware TO set and software TO clear in the same cycle SHALL leave TO=1 (set wins).
REQ-021 Software write of EN=1 in the cycle a one-shot timeout clears EN SHALL leave EN=1 with COUNT=PERIOD.
REQ-022 irq SHALL be registered OR over channels of (TO & IE), asserting one cycle after TO sets.

Reset
REQ-023 Asserting reset_reset SHALL immediately clear all CTRL, PERIOD, COUNT, STATUS, COMPARE, avs_readdata, irq, tick_export and pwm_export to 0, including mid-count.
REQ-024 First counting edge after reset deassertion SHALL require a fresh EN write.

Configuration
REQ-025 Macro MULTI_TIMER_PWM_EN SHALL compile in COMPARE registers and PWM logic.
REQ-026 With MULTI_TIMER_PWM_EN: pwm_export[ch] SHALL be registered (EN & COUNT < COMPARE), duty = COMPARE/(PERIOD+1).
REQ-027 Without MULTI_TIMER_PWM_EN: COMPARE SHALL read 0, ignore writes, and pwm_export SHALL be constant 0; port list unchanged.

Structure
REQ-028 Package multi_timer_pkg SHALL hold register offset constants, CTRL/STATUS bit indices, and the 8-word channel stride.
REQ-029 Sub-module timer_channel SHALL implement one channel (registers, counter, tick, PWM) and be generated N_CH times; top level SHALL hold address decode, read mux and irq OR.

Verification
REQ-030 PERIOD=9, CTRL=0b011 on ch0 -> tick_export[0] every 10 cycles, COUNT reads 9..0 cyclically.
REQ-031 PERIOD=4, CTRL=0b101 (one-shot, IE) on ch1 -> single tick 5 cycles after enable, EN reads 0, irq high next cycle; STATUS write 1 -> irq low next cycle.
REQ-032 TO-clear write coincident with ch2 timeout -> STATUS.TO reads 1, irq stays high.
REQ-033 reset_reset pulsed mid-count (COUNT=3) -> all outputs 0 immediately, COUNT reads 0, no tick after release.
REQ-034 PWM build, PERIOD=3, COMPARE=1, CONT+EN -> pwm_export[0] high 1 of every 4 cycles; non-PWM build -> COMPARE reads 0, pwm_export 0.
REQ-035 N_CH=1, CNT_W=8, PERIOD write 0x1FF -> reads 0xFF, tick every 256 cycles.
